// File: rtl/avalon_bus_arbiter.sv
// Two-port arbiter sharing one Avalon-MM master between instruction fetch and data access.
// One transaction outstanding at a time; each completion returns a single-cycle ack.
module avalon_bus_arbiter #(
   parameter bit ROUND_ROBIN     = 1'b1,
   parameter bit RESET_LAST_DATA = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteenable,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   output logic        busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] BUS_I = 3'd1;
   localparam logic [2:0] BUS_D = 3'd2;
   localparam logic [2:0] ACK_I = 3'd3;
   localparam logic [2:0] ACK_D = 3'd4;

   logic [2:0] state_r;
   logic       last_data_r;
   logic       grant_d_s;
   logic       any_req_s;

   assign any_req_s = i_req | d_req;

   // Pick the data port for this IDLE cycle; on a tie either alternate or favour data.
   always_comb begin
      grant_d_s = 1'b0;
      if (d_req && !i_req) begin
         grant_d_s = 1'b1;
      end else if (d_req && i_req) begin
         grant_d_s = ROUND_ROBIN ? !last_data_r : 1'b1;
      end else begin
         grant_d_s = 1'b0;
      end
   end

   // Transaction sequencer and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         last_data_r <= RESET_LAST_DATA;
         address     <= 32'h0000_0000;
         read        <= 1'b0;
         write       <= 1'b0;
         writedata   <= 32'h0000_0000;
         byteenable  <= 4'b0000;
         i_ack       <= 1'b0;
         d_ack       <= 1'b0;
         i_rdata     <= 32'h0000_0000;
         d_rdata     <= 32'h0000_0000;
         busy        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               if (any_req_s && grant_d_s) begin
                  state_r    <= BUS_D;
                  address    <= d_addr;
                  byteenable <= d_byteenable;
                  writedata  <= d_wdata;
                  read       <= !d_write;
                  write      <= d_write;
                  busy       <= 1'b1;
               end else if (any_req_s) begin
                  state_r    <= BUS_I;
                  address    <= i_addr;
                  byteenable <= 4'b1111;
                  read       <= 1'b1;
                  write      <= 1'b0;
                  busy       <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            BUS_I: begin
               if (!waitrequest) begin
                  read        <= 1'b0;
                  write       <= 1'b0;
                  i_rdata     <= readdata;
                  last_data_r <= 1'b0;
                  i_ack       <= 1'b1;
                  state_r     <= ACK_I;
               end else begin
                  state_r <= BUS_I;
               end
            end
            BUS_D: begin
               if (!waitrequest) begin
                  // Stores leave the load-data register untouched.
                  if (read) begin
                     d_rdata <= readdata;
                  end else begin
                     d_rdata <= d_rdata;
                  end
                  read        <= 1'b0;
                  write       <= 1'b0;
                  last_data_r <= 1'b1;
                  d_ack       <= 1'b1;
                  state_r     <= ACK_D;
               end else begin
                  state_r <= BUS_D;
               end
            end
            ACK_I: begin
               i_ack   <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            ACK_D: begin
               d_ack   <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               read    <= 1'b0;
               write   <= 1'b0;
               i_ack   <= 1'b0;
               d_ack   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: directed scenarios plus a randomized
// transaction-level reference model of the arbitration and bus protocol.
module tb_avalon_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset, i_req, d_req, d_write, waitrequest;
   logic [31:0] i_addr, d_addr, d_wdata, readdata;
   logic [3:0]  d_byteenable;

   logic        i_ack, d_ack, read, write, busy;
   logic [31:0] i_rdata, d_rdata, address, writedata;
   logic [3:0]  byteenable;

   logic        fp_i_ack, fp_d_ack, fp_read, fp_write, fp_busy;
   logic [31:0] fp_i_rdata, fp_d_rdata, fp_address, fp_writedata;
   logic [3:0]  fp_byteenable;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_i_rdata, exp_d_rdata, exp_wdata;

   always #5 clk = ~clk;

   avalon_bus_arbiter #(.ROUND_ROBIN(1'b1), .RESET_LAST_DATA(1'b0)) dut (
      .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata), .address(address),
      .write(write), .read(read), .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata), .busy(busy));

   avalon_bus_arbiter #(.ROUND_ROBIN(1'b0), .RESET_LAST_DATA(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(fp_i_ack), .i_rdata(fp_i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteenable(d_byteenable), .d_ack(fp_d_ack), .d_rdata(fp_d_rdata), .address(fp_address),
      .write(fp_write), .read(fp_read), .waitrequest(waitrequest), .writedata(fp_writedata),
      .byteenable(fp_byteenable), .readdata(readdata), .busy(fp_busy));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_byteenable = 4'h0; readdata = 32'h0;
      tick;
      reset = 1'b0;
      exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; exp_wdata = 32'h0;
   endtask

   task automatic test_reset;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_byteenable = 4'h0; readdata = 32'h0;
      tick;
      tick;
      checks++; if ({read, write, i_ack, d_ack, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {read, write, i_ack, d_ack, busy}); end
      checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_address: got %h expected 0", address); end
      checks++; if (writedata !== 32'h0) begin errors++; $display("FAIL reset_writedata: got %h expected 0", writedata); end
      checks++; if (byteenable !== 4'h0) begin errors++; $display("FAIL reset_byteenable: got %h expected 0", byteenable); end
      checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", i_rdata, d_rdata); end
      reset = 1'b0;
      exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; exp_wdata = 32'h0;
      tick;
      checks++; if ({read, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", {read, busy}); end
   endtask

   task automatic test_fetch;
      i_req = 1'b1; i_addr = 32'hBFC0_0000; waitrequest = 1'b0; readdata = 32'h3C08_0001;
      tick;
      checks++; if ({read, write, busy} !== 3'b101) begin errors++; $display("FAIL fetch_strobe: got %b expected 101", {read, write, busy}); end
      checks++; if (address !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_address: got %h expected bfc00000", address); end
      checks++; if (byteenable !== 4'hF) begin errors++; $display("FAIL fetch_byteenable: got %h expected f", byteenable); end
      tick;
      exp_i_rdata = 32'h3C08_0001;
      checks++; if ({i_ack, d_ack, read} !== 3'b100) begin errors++; $display("FAIL fetch_ack: got %b expected 100", {i_ack, d_ack, read}); end
      checks++; if (i_rdata !== exp_i_rdata) begin errors++; $display("FAIL fetch_rdata: got %h expected %h", i_rdata, exp_i_rdata); end
      i_req = 1'b0;
      tick;
      checks++; if ({i_ack, busy} !== 2'b00) begin errors++; $display("FAIL fetch_done: got %b expected 00", {i_ack, busy}); end
   endtask

   task automatic test_store_wait;
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF;
      d_byteenable = 4'b0011; waitrequest = 1'b1; readdata = 32'h5555_AAAA;
      tick;
      for (int k = 0; k < 4; k++) begin
         checks++; if ({read, write, d_ack} !== 3'b010) begin errors++; $display("FAIL store_strobe%0d: got %b expected 010", k, {read, write, d_ack}); end
         checks++; if ({address, writedata, byteenable} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'b0011}) begin errors++; $display("FAIL store_hold%0d: got %h %h %h expected 00001000 deadbeef 3", k, address, writedata, byteenable); end
         if (k == 3) waitrequest = 1'b0;
         tick;
      end
      exp_wdata = 32'hDEAD_BEEF;
      checks++; if ({d_ack, i_ack, write} !== 3'b100) begin errors++; $display("FAIL store_ack: got %b expected 100", {d_ack, i_ack, write}); end
      checks++; if (d_rdata !== exp_d_rdata) begin errors++; $display("FAIL store_d_rdata: got %h expected %h", d_rdata, exp_d_rdata); end
      d_req = 1'b0;
      tick;
   endtask

   task automatic test_load_be;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_2000; d_byteenable = 4'b1000;
      waitrequest = 1'b0; readdata = 32'h1234_5678;
      tick;
      checks++; if ({read, write} !== 2'b10) begin errors++; $display("FAIL load_strobe: got %b expected 10", {read, write}); end
      checks++; if (byteenable !== 4'b1000) begin errors++; $display("FAIL load_byteenable: got %b expected 1000", byteenable); end
      tick;
      exp_d_rdata = 32'h1234_5678;
      checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL load_ack: got %b expected 1", d_ack); end
      checks++; if (d_rdata !== exp_d_rdata) begin errors++; $display("FAIL load_d_rdata: got %h expected %h", d_rdata, exp_d_rdata); end
      checks++; if (i_rdata !== exp_i_rdata) begin errors++; $display("FAIL load_i_rdata: got %h expected %h", i_rdata, exp_i_rdata); end
      d_req = 1'b0;
      tick;
   endtask

   // Both requests held: acks land every third cycle after release, D first then alternating.
   task automatic test_round_robin;
      logic exp_i, exp_d;
      apply_reset;
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_write = 1'b0;
      d_byteenable = 4'hF; waitrequest = 1'b0; readdata = 32'h0BAD_F00D;
      for (int c = 1; c <= 12; c++) begin
         tick;
         exp_d = (c % 3 == 2) && ((c / 3) % 2 == 0);
         exp_i = (c % 3 == 2) && ((c / 3) % 2 == 1);
         checks++; if ({i_ack, d_ack} !== {exp_i, exp_d}) begin errors++; $display("FAIL rr_ack_c%0d: got %b expected %b", c, {i_ack, d_ack}, {exp_i, exp_d}); end
      end
      i_req = 1'b0; d_req = 1'b0;
      tick;
      tick;
   endtask

   task automatic test_fixed_priority;
      logic exp_d;
      apply_reset;
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_write = 1'b0;
      d_byteenable = 4'hF; waitrequest = 1'b0; readdata = 32'h0BAD_F00D;
      for (int c = 1; c <= 12; c++) begin
         tick;
         exp_d = (c % 3 == 2);
         checks++; if ({fp_i_ack, fp_d_ack} !== {1'b0, exp_d}) begin errors++; $display("FAIL fp_ack_c%0d: got %b expected %b", c, {fp_i_ack, fp_d_ack}, {1'b0, exp_d}); end
         if (c % 3 == 1) begin
            checks++; if (fp_address !== 32'h0000_0200) begin errors++; $display("FAIL fp_address_c%0d: got %h expected 00000200", c, fp_address); end
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      tick;
      tick;
   endtask

   task automatic test_reset_midflight;
      apply_reset;
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'hCAFE_0000;
      d_byteenable = 4'hF; waitrequest = 1'b1;
      tick;
      tick;
      checks++; if (write !== 1'b1) begin errors++; $display("FAIL mid_write: got %b expected 1", write); end
      reset = 1'b1; d_req = 1'b0; i_req = 1'b1; i_addr = 32'hBFC0_0040;
      tick;
      checks++; if ({read, write, busy, d_ack} !== 4'b0000) begin errors++; $display("FAIL mid_reset: got %b expected 0000", {read, write, busy, d_ack}); end
      reset = 1'b0;
      exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; exp_wdata = 32'h0;
      tick;
      checks++; if ({read, write, d_ack} !== 3'b100 || address !== 32'hBFC0_0040) begin errors++; $display("FAIL mid_fetch: got %b %h expected 100 bfc00040", {read, write, d_ack}, address); end
      waitrequest = 1'b0; readdata = 32'hA5A5_0001;
      tick;
      exp_i_rdata = 32'hA5A5_0001;
      checks++; if ({i_ack, d_ack} !== 2'b10 || i_rdata !== exp_i_rdata) begin errors++; $display("FAIL mid_ack: got %b %h expected 10 %h", {i_ack, d_ack}, i_rdata, exp_i_rdata); end
      i_req = 1'b0;
      tick;
   endtask

   // Transaction-level model: pending requests per port, last-served port, random wait states.
   task automatic test_random;
      logic pend_i, pend_d, pd_write, last_d, win_d;
      logic [31:0] pi_addr, pd_addr, pd_wdata, rd, exp_addr;
      logic [3:0] pd_be, exp_be;
      logic [1:0] exp_rw;
      int w;
      apply_reset;
      pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b0;
      pi_addr = 32'h0; pd_addr = 32'h0; pd_wdata = 32'h0; pd_be = 4'h0; pd_write = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (!pend_i && ($urandom_range(1, 0) == 1)) begin
            pend_i = 1'b1; pi_addr = $urandom;
         end
         if (!pend_d && (($urandom_range(1, 0) == 1) || !pend_i)) begin
            pend_d = 1'b1; pd_write = 1'($urandom_range(1, 0)); pd_addr = $urandom;
            pd_wdata = $urandom; pd_be = 4'($urandom_range(15, 1));
         end
         i_req = pend_i; i_addr = pi_addr;
         d_req = pend_d; d_write = pd_write; d_addr = pd_addr; d_wdata = pd_wdata; d_byteenable = pd_be;
         waitrequest = 1'($urandom_range(1, 0));
         win_d = pend_d && (!pend_i || !last_d);
         if (win_d) begin
            exp_addr = pd_addr; exp_be = pd_be; exp_wdata = pd_wdata; exp_rw = {!pd_write, pd_write};
         end else begin
            exp_addr = pi_addr; exp_be = 4'hF; exp_rw = 2'b10;
         end
         w = $urandom_range(3, 0);
         tick;
         for (int j = 0; j <= w; j++) begin
            checks++; if ({read, write} !== exp_rw) begin errors++; $display("FAIL rnd_rw t%0d: got %b expected %b", t, {read, write}, exp_rw); end
            checks++; if ({address, byteenable, writedata} !== {exp_addr, exp_be, exp_wdata}) begin errors++; $display("FAIL rnd_bus t%0d: got %h %h %h expected %h %h %h", t, address, byteenable, writedata, exp_addr, exp_be, exp_wdata); end
            checks++; if ({i_ack, d_ack, busy} !== 3'b001) begin errors++; $display("FAIL rnd_wait t%0d: got %b expected 001", t, {i_ack, d_ack, busy}); end
            waitrequest = (j < w);
            readdata = $urandom;
            rd = readdata;
            tick;
         end
         if (win_d) begin
            if (!pd_write) exp_d_rdata = rd;
            last_d = 1'b1; pend_d = 1'b0; d_req = 1'b0;
         end else begin
            exp_i_rdata = rd;
            last_d = 1'b0; pend_i = 1'b0; i_req = 1'b0;
         end
         checks++; if ({i_ack, d_ack, read, write} !== {!win_d, win_d, 2'b00}) begin errors++; $display("FAIL rnd_ack t%0d: got %b expected %b", t, {i_ack, d_ack, read, write}, {!win_d, win_d, 2'b00}); end
         checks++; if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin errors++; $display("FAIL rnd_rdata t%0d: got %h %h expected %h %h", t, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata); end
         tick;
         checks++; if ({i_ack, d_ack, busy} !== 3'b000) begin errors++; $display("FAIL rnd_idle t%0d: got %b expected 000", t, {i_ack, d_ack, busy}); end
      end
      i_req = 1'b0; d_req = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_store_wait;
      test_load_be;
      test_round_robin;
      test_fixed_priority;
      test_reset_midflight;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
